// File: rtl/hex_counter_7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex_counter_7seg
// Brief    : Divider-ticked 4-bit hex up/down/load counter with an active-low
//            seven-segment decoder. Define HEXCNT_DIV_BYPASS_EN to tick on
//            every clock (fast simulation).
// Revision : 1.0 - initial release
// ============================================================================
module hex_counter_7seg #(
    parameter int BITS = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [1:0] S,
    input  logic [3:0] D,
    output logic [6:0] SEG
);

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;

    logic       tick;
    logic [3:0] q;

`ifdef HEXCNT_DIV_BYPASS_EN
    assign tick = 1'b1;
`else
    logic [BITS-1:0] div_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Enable pulse, not a clock: one cycle high every 2^BITS cycles.
    assign tick = &div_cnt;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            q <= 4'h0;
        end else if (tick && EN) begin
            case (S)
                MODE_LOAD: q <= D;
                MODE_UP:   q <= q + 4'h1;
                MODE_DOWN: q <= q - 4'h1;
                default:   q <= q;
            endcase
        end
    end

    // Active-low patterns, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        SEG = 7'b1111111;
        case (q)
            4'h0: SEG = 7'b1000000;
            4'h1: SEG = 7'b1111001;
            4'h2: SEG = 7'b0100100;
            4'h3: SEG = 7'b0110000;
            4'h4: SEG = 7'b0011001;
            4'h5: SEG = 7'b0010010;
            4'h6: SEG = 7'b0000010;
            4'h7: SEG = 7'b1111000;
            4'h8: SEG = 7'b0000000;
            4'h9: SEG = 7'b0010000;
            4'hA: SEG = 7'b0001000;
            4'hB: SEG = 7'b0000011;
            4'hC: SEG = 7'b1000110;
            4'hD: SEG = 7'b0100001;
            4'hE: SEG = 7'b0000110;
            4'hF: SEG = 7'b0001110;
            default: SEG = 7'b1111111;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_counter_7seg.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_counter_7seg
// Brief    : Directed plus randomized bench for hex_counter_7seg (BITS=4),
//            checked against an edge-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_counter_7seg;

    localparam int BITS = 4;
`ifdef HEXCNT_DIV_BYPASS_EN
    localparam int PER = 1;
`else
    localparam int PER = 1 << BITS;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [1:0] s   = 2'b00;
    logic [3:0] d   = 4'h0;
    logic [6:0] seg;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: edges since reset release, and the counter value.
    int         k  = 0;
    logic [3:0] mq = 4'h0;

    logic [6:0] seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    hex_counter_7seg #(.BITS(BITS)) dut (
        .CLK (clk),
        .RST (rst),
        .EN  (en),
        .S   (s),
        .D   (d),
        .SEG (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] exp);
        n_assert++;
        assert (seg === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, seg, exp);
        end
    endtask

    // One clock edge: update the model from the inputs seen at the edge,
    // then check SEG shortly after.
    task automatic cyc(input string tag);
        @(posedge clk);
        if (rst) begin
            k  = 0;
            mq = 4'h0;
        end else begin
            k++;
            if ((k % PER) == 0 && en) begin
                case (s)
                    2'b00: mq = d;
                    2'b01: mq = (mq + 1) % 16;
                    2'b10: mq = (mq + 15) % 16;
                    default: ;
                endcase
            end
        end
        #1;
        check(tag, seg_tbl[mq]);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    initial begin
        // Reset with count-down selected, then wrap all the way round.
        rst = 1'b1; en = 1'b1; s = 2'b10; d = 4'h0;
        for (int i = 0; i < 8; i++) begin
            cyc("reset");
            check("reset_zero", 7'b1000000);
        end
        rst = 1'b0;
        run("down", 16);
        if (PER == 16) check("down_first_F", 7'b0001110);
        run("down", 240);
        if (PER == 16) check("down_wrap_0", 7'b1000000);

        // Count up through all 16 patterns and F->0 wrap.
        rst = 1'b1; cyc("reset2"); rst = 1'b0;
        s = 2'b01;
        run("up", 17 * PER);

        // Load A, with D disturbed mid-period.
        rst = 1'b1; cyc("reset3"); rst = 1'b0;
        s = 2'b00; d = 4'hA;
        run("load", PER);
        if (PER == 16) check("load_A", 7'b0001000);
        run("load", PER / 2);
        d = 4'h3;
        run("load_mid", PER - PER / 2);
        d = 4'h7;
        run("load_next", 2 * PER);

        // EN low for 40 edges, then raised: tick phase preserved.
        rst = 1'b1; cyc("reset4"); rst = 1'b0;
        s = 2'b01; en = 1'b0;
        run("en_off", 40);
        en = 1'b1;
        run("en_on", 8);
        if (PER == 16) check("en_phase_1", 7'b1111001);
        run("en_on", PER);

        // Hold for several ticks.
        s = 2'b11;
        run("hold", 4 * PER);

        // Reset pulse at edge 20 with Q nonzero.
        rst = 1'b1; cyc("reset5"); rst = 1'b0;
        s = 2'b01;
        run("pre_pulse", 19);
        rst = 1'b1; cyc("pulse"); rst = 1'b0;
        run("post_pulse", 3 * PER);

        // Randomized inputs changing every cycle, occasional reset.
        for (int i = 0; i < 1500; i++) begin
            s   = 2'($urandom_range(0, 3));
            d   = 4'($urandom_range(0, 15));
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cyc("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
